// File: rtl/siren_detector.sv
// siren_detector
//   Watches a siren tone line and measures every half-period, including both
//   rising and falling edges. It locks (detected=1) after CONFIRM consecutive
//   half-periods that fall in the range [MIN_HALF, MAX_HALF]. It drops lock on
//   an out-of-range half-period or when the tone goes quiet.
//
// Ports:
//   clock         in   system clock, rising edge
//   reset         in   synchronous, active-high
//   tone_in       in   monitored tone line, asynchronous to clock
//   detected      out  high while locked onto a valid siren
//   half_period   out  last measured half-period in clocks (18 bits)
//   sample_strobe out  one-cycle pulse when half_period updates
//   fault         out  one-cycle pulse when lock is lost
module siren_detector #(
  parameter int unsigned MIN_HALF = 65000,
  parameter int unsigned MAX_HALF = 131000,
  parameter int unsigned CONFIRM  = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        tone_in,
  output logic        detected,
  output logic [17:0] half_period,
  output logic        sample_strobe,
  output logic        fault
);

  localparam logic [17:0] MIN_L  = 18'(MIN_HALF);
  localparam logic [17:0] MAX_L  = 18'(MAX_HALF);
  localparam logic [17:0] SAT_L  = 18'(MAX_HALF + 1);
  localparam logic [3:0]  CONF_L = 4'(CONFIRM);

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    LOCKED
  } state_t;

  state_t      state_q, state_d;
  logic        s0_q, s0_d;
  logic        s1_q, s1_d;
  logic        prev_q, prev_d;
  logic [17:0] cnt_q, cnt_d;
  logic [3:0]  good_q, good_d;
  logic        detected_q, detected_d;
  logic [17:0] half_period_q, half_period_d;
  logic        sample_strobe_q, sample_strobe_d;
  logic        fault_q, fault_d;

  logic        tone_edge;
  logic        sat;
  logic        in_range;
  logic [17:0] cnt_inc;
  logic [3:0]  good_inc;

  always_comb begin
    tone_edge = s1_q ^ prev_q;
    // The counter reaching MAX_HALF+1 without an edge is the loss-of-tone
    // condition. An edge arriving on that same cycle wins and is rejected
    // as out of range.
    sat       = (cnt_q == SAT_L);
    in_range  = (cnt_q >= MIN_L) && (cnt_q <= MAX_L);
    cnt_inc   = sat ? cnt_q : cnt_q + 18'd1;
    good_inc  = good_q + 4'd1;

    s0_d            = tone_in;
    s1_d            = s0_q;
    prev_d          = s1_q;
    state_d         = state_q;
    cnt_d           = cnt_q;
    good_d          = good_q;
    detected_d      = detected_q;
    half_period_d   = half_period_q;
    sample_strobe_d = 1'b0;
    fault_d         = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        good_d = '0;
        if (tone_edge) begin
          state_d = MEASURE;
          cnt_d   = 18'd1;
        end
      end

      MEASURE: begin
        if (tone_edge) begin
          cnt_d           = 18'd1;
          half_period_d   = cnt_q;
          sample_strobe_d = 1'b1;
          if (in_range) begin
            good_d = good_inc;
            if (good_inc == CONF_L) begin
              state_d    = LOCKED;
              detected_d = 1'b1;
            end
          end else begin
            good_d = '0;
          end
        end else if (sat) begin
          state_d = IDLE;
          cnt_d   = '0;
          good_d  = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      LOCKED: begin
        if (tone_edge) begin
          cnt_d           = 18'd1;
          half_period_d   = cnt_q;
          sample_strobe_d = 1'b1;
          if (!in_range) begin
            state_d    = IDLE;
            cnt_d      = '0;
            good_d     = '0;
            detected_d = 1'b0;
            fault_d    = 1'b1;
          end
        end else if (sat) begin
          state_d    = IDLE;
          cnt_d      = '0;
          good_d     = '0;
          detected_d = 1'b0;
          fault_d    = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      default: begin
        state_d    = IDLE;
        cnt_d      = '0;
        good_d     = '0;
        detected_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= IDLE;
      s0_q            <= 1'b0;
      s1_q            <= 1'b0;
      prev_q          <= 1'b0;
      cnt_q           <= '0;
      good_q          <= '0;
      detected_q      <= 1'b0;
      half_period_q   <= '0;
      sample_strobe_q <= 1'b0;
      fault_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      s0_q            <= s0_d;
      s1_q            <= s1_d;
      prev_q          <= prev_d;
      cnt_q           <= cnt_d;
      good_q          <= good_d;
      detected_q      <= detected_d;
      half_period_q   <= half_period_d;
      sample_strobe_q <= sample_strobe_d;
      fault_q         <= fault_d;
    end
  end

  assign detected      = detected_q;
  assign half_period   = half_period_q;
  assign sample_strobe = sample_strobe_q;
  assign fault         = fault_q;

endmodule

// File: tb/tb_siren_detector.sv
// tb_siren_detector
//   Directed bench for siren_detector with MIN_HALF=8, MAX_HALF=20, CONFIRM=4.
//   Each half-period interval is measured by the toggle that ends it.
module tb_siren_detector;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        tone_in = 1'b0;
  logic        detected;
  logic [17:0] half_period;
  logic        sample_strobe;
  logic        fault;

  siren_detector #(
    .MIN_HALF (8),
    .MAX_HALF (20),
    .CONFIRM  (4)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .tone_in       (tone_in),
    .detected      (detected),
    .half_period   (half_period),
    .sample_strobe (sample_strobe),
    .fault         (fault)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Event log filled by the monitor; phases index it relative to a base.
  logic [17:0] hp_log  [256];
  logic        det_log [256];
  int          n_strobe = 0;
  int          n_fault  = 0;
  int          cyc      = 0;
  int          last_strobe_cyc = -1;
  int          fault_cyc = -1000;
  logic        fault_det = 1'b1;
  int          base_s = 0;
  int          base_f = 0;

  always @(posedge clock) begin
    #1;
    cyc++;
    if (sample_strobe) begin
      if (n_strobe < 256) begin
        hp_log[n_strobe]  = half_period;
        det_log[n_strobe] = detected;
      end
      n_strobe++;
      last_strobe_cyc = cyc;
    end
    if (fault) begin
      n_fault++;
      fault_cyc = cyc;
      fault_det = detected;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic mark();
    base_s = n_strobe;
    base_f = n_fault;
  endtask

  function automatic logic [31:0] hp_at(input int i);
    return 32'(hp_log[(base_s + i) % 256]);
  endfunction

  function automatic logic [31:0] det_at(input int i);
    return 32'(det_log[(base_s + i) % 256]);
  endfunction

  // Toggle the line, then hold it for h clocks.
  task automatic run_half(input int h);
    tone_in = ~tone_in;
    repeat (h) @(posedge clock);
    #1;
  endtask

  task automatic pulse_reset();
    reset   = 1'b1;
    tone_in = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  int sweep [13] = '{20, 18, 16, 14, 12, 10, 8, 10, 12, 14, 16, 18, 20};
  int meas  [9]  = '{12, 12, 12, 7, 12, 12, 12, 12, 12};

  initial begin
    // Power-on reset
    repeat (3) @(posedge clock);
    #1;
    check("rst_detected", 32'(detected), 32'd0);
    check("rst_half_period", 32'(half_period), 32'd0);
    check("rst_strobe", 32'(sample_strobe), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;

    // Lock at half-period 12: first edge arms, 4 samples lock
    mark();
    repeat (5) run_half(12);
    check("lock_nstrobe", 32'(n_strobe - base_s), 32'd4);
    check("lock_hp0", hp_at(0), 32'd12);
    check("lock_hp3", hp_at(3), 32'd12);
    check("lock_det_s3", det_at(2), 32'd0);
    check("lock_det_s4", det_at(3), 32'd1);
    check("lock_nofault", 32'(n_fault - base_f), 32'd0);

    // Sweep 20..8..20 while locked, then a 7 breaks lock
    mark();
    foreach (sweep[i]) run_half(sweep[i]);
    run_half(7);
    run_half(10);
    check("sweep_nstrobe", 32'(n_strobe - base_s), 32'd15);
    check("sweep_hp_first", hp_at(1), 32'd20);
    check("sweep_hp_min", hp_at(7), 32'd8);
    check("sweep_hp_last", hp_at(13), 32'd20);
    check("sweep_det_held", det_at(13), 32'd1);
    check("sweep_hp_7", hp_at(14), 32'd7);
    check("sweep_fault_cnt", 32'(n_fault - base_f), 32'd1);
    check("sweep_fault_cyc", 32'(fault_cyc - last_strobe_cyc), 32'd0);
    check("sweep_fault_det", 32'(fault_det), 32'd0);
    check("sweep_det_end", 32'(detected), 32'd0);

    // Too slow: 21 lands on the saturation cycle and is rejected
    mark();
    repeat (5) run_half(21);
    check("slow_nstrobe", 32'(n_strobe - base_s), 32'd4);
    check("slow_hp0", hp_at(0), 32'd21);
    check("slow_hp3", hp_at(3), 32'd21);
    check("slow_det", 32'(detected), 32'd0);
    check("slow_nofault", 32'(n_fault - base_f), 32'd0);

    // Switch to 15: first sample still 21, then 4 good samples lock
    mark();
    repeat (5) run_half(15);
    check("relock_hp0", hp_at(0), 32'd21);
    check("relock_hp4", hp_at(4), 32'd15);
    check("relock_det_s4", det_at(3), 32'd0);
    check("relock_det_s5", det_at(4), 32'd1);
    check("relock_det", 32'(detected), 32'd1);

    // Loss of tone: hold the line, fault 21 clocks after last edge
    for (int i = 0; i < 40 && n_fault == base_f; i++) @(posedge clock);
    #2;
    check("lost_fault_cnt", 32'(n_fault - base_f), 32'd1);
    check("lost_fault_delay", 32'(fault_cyc - last_strobe_cyc), 32'd21);
    check("lost_det", 32'(detected), 32'd0);

    // Reset mid-lock
    mark();
    repeat (5) run_half(12);
    check("mid_det_locked", 32'(detected), 32'd1);
    mark();
    pulse_reset();
    check("mid_rst_detected", 32'(detected), 32'd0);
    check("mid_rst_hp", 32'(half_period), 32'd0);
    check("mid_rst_strobe", 32'(sample_strobe), 32'd0);
    check("mid_rst_fault", 32'(fault), 32'd0);
    repeat (30) @(posedge clock);
    #1;
    check("mid_rst_nofault", 32'(n_fault - base_f), 32'd0);
    mark();
    repeat (5) run_half(12);
    check("mid_relock_nstrobe", 32'(n_strobe - base_s), 32'd4);
    check("mid_relock_s4", det_at(2), 32'd0);
    check("mid_relock_s5", det_at(3), 32'd1);

    // A 7 in MEASURE clears the good count
    pulse_reset();
    repeat (3) @(posedge clock);
    #1;
    mark();
    foreach (meas[i]) run_half(meas[i]);
    check("good_nstrobe", 32'(n_strobe - base_s), 32'd8);
    check("good_hp7", hp_at(3), 32'd7);
    check("good_det_s7", det_at(6), 32'd0);
    check("good_det_s8", det_at(7), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
